// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch stage with one outstanding imem request and a one-entry buffer toward the core.
// Define IFU_MISALIGN_TRAP_EN to turn misaligned redirects into a FAULT marker instead of silently aligning them.
module ifu_fetch #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_cmd,
    output logic [XLEN-1:0] inst_pc,
    output logic            inst_fault
);

`ifdef IFU_MISALIGN_TRAP_EN
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_FAULT, S_STALL} state_t;
    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;
`else
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;
`endif

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            drop_q, drop_d;
    logic [XLEN-1:0] cmd_q, cmd_d;
    logic [XLEN-1:0] ipc_q, ipc_d;
    logic [XLEN-1:0] redir_target;

`ifdef IFU_MISALIGN_TRAP_EN
    logic redir_misaligned;
    assign redir_target     = redirect_pc;
    assign redir_misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign inst_valid       = (state_q == S_HOLD) || (state_q == S_FAULT);
    assign inst_fault       = (state_q == S_FAULT);
`else
    assign redir_target = redirect_pc & ~{{(XLEN-2){1'b0}}, 2'b11};
    assign inst_valid   = (state_q == S_HOLD);
    assign inst_fault   = 1'b0;
`endif

    assign imem_req_valid = (state_q == S_REQ);
    assign imem_req_addr  = pc_q;
    assign inst_cmd       = cmd_q;
    assign inst_pc        = ipc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            drop_q  <= 1'b0;
            cmd_q   <= '0;
            ipc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
            cmd_q   <= cmd_d;
            ipc_q   <= ipc_d;
        end
    end

    // drop marks an in-flight response that belongs to a squashed (wrong-path) fetch
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        drop_d  = drop_q;
        cmd_d   = cmd_q;
        ipc_d   = ipc_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                if (redirect_valid) pc_d = redir_target;
            end
            S_REQ: begin
                if (redirect_valid) pc_d = redir_target;
                if (imem_req_ready) begin
                    state_d = S_WAIT;
                    if (redirect_valid) drop_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    pc_d = redir_target;
                    if (imem_resp_valid) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        drop_d = 1'b1;
                    end
                end else if (imem_resp_valid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        cmd_d   = imem_resp_data;
                        ipc_d   = pc_q;
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    pc_d    = redir_target;
                    state_d = S_REQ;
                end else if (inst_ready) begin
                    pc_d    = pc_q + XLEN'(4);
                    state_d = S_REQ;
                end
            end
`ifdef IFU_MISALIGN_TRAP_EN
            // A request issued before the fault may still be in flight; wait it out before refetching.
            S_FAULT: begin
                if (imem_resp_valid) drop_d = 1'b0;
                if (redirect_valid) begin
                    pc_d    = redir_target;
                    state_d = drop_d ? S_WAIT : S_REQ;
                end else if (inst_ready) begin
                    state_d = S_STALL;
                end
            end
            S_STALL: begin
                if (imem_resp_valid) drop_d = 1'b0;
                if (redirect_valid) begin
                    pc_d    = redir_target;
                    state_d = drop_d ? S_WAIT : S_REQ;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

`ifdef IFU_MISALIGN_TRAP_EN
        if (redir_misaligned) begin
            state_d = S_FAULT;
            pc_d    = redirect_pc;
            cmd_d   = NOP;
            ipc_d   = redirect_pc;
            case (state_q)
                S_REQ:   drop_d = imem_req_ready;
                S_WAIT:  drop_d = !imem_resp_valid;
                default: ;
            endcase
        end
`endif
    end

endmodule
